// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the execute-stage divide sequencer.
// The request struct and the divide-by-zero quotient are sized by DIV_DATA_W.
// Instances must keep DATA_W equal to this value.
package div_seq_ctrl_pkg;

  localparam int DIV_DATA_W = 32;

  // Sequencer states: waiting for a request, core running, result held.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Operands captured at acceptance and held steady for the core.
  typedef struct packed {
    logic                  is_signed;
    logic [DIV_DATA_W-1:0] op1;
    logic [DIV_DATA_W-1:0] op2;
  } div_req_t;

  // Quotient reported for a zero divisor.
  localparam logic [DIV_DATA_W-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_fastpath_chk.sv
// Combinational detector for divides whose result is known without the core.
// Only instantiated when DIV_FASTPATH_EN is defined.
//   divisor zero          -> {dividend, all-ones}
//   dividend zero         -> 0
//   unsigned, a < b       -> {dividend, 0}
module div_fastpath_chk
  import div_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                is_signed,
  input  logic [DATA_W-1:0]   op1,
  input  logic [DATA_W-1:0]   op2,
  output logic                hit,
  output logic [2*DATA_W-1:0] result
);

  // Priority-ordered trivial-case detection; divide-by-zero wins over a zero dividend.
  always_comb begin
    hit    = 1'b0;
    result = '0;
    if (op2 == '0) begin
      hit    = 1'b1;
      result = {op1, DIV_ZERO_QUOT};
    end else if (op1 == '0) begin
      hit    = 1'b1;
      result = '0;
    end else if (!is_signed && (op1 < op2)) begin
      hit    = 1'b1;
      result = {op1, {DATA_W{1'b0}}};
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Execute-stage sequencer for the multicycle DIV/DIVU core.
// Latches operands at acceptance, runs the core start/annul handshake, raises
// the E-stage stall while the core works, and holds the {hi,lo} result while
// the pipeline is frozen by other stall sources so a held instruction never
// restarts the core. Flush cancels an in-flight divide.
// Optional build macro: DIV_FASTPATH_EN (trivial divides bypass the core).
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_signed,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  input  logic                flush,
  input  logic                stall_ext,
  output logic                div_start,
  output logic                div_annul,
  output logic                div_signed,
  output logic [DATA_W-1:0]   div_op1,
  output logic [DATA_W-1:0]   div_op2,
  input  logic [2*DATA_W-1:0] div_result,
  input  logic                div_ready,
  output logic                stall_req,
  output logic [2*DATA_W-1:0] result,
  output logic                result_valid,
  output logic [CNT_W-1:0]    div_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  div_state_t          state_q,  state_d;
  div_req_t            req_q,    req_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                valid_q,  valid_d;
  logic                start_q,  start_d;

  logic                fast_hit;
  logic [2*DATA_W-1:0] fast_result;

`ifdef DIV_FASTPATH_EN
  div_fastpath_chk #(
    .DATA_W (DATA_W)
  ) u_fastpath (
    .is_signed (req_signed),
    .op1       (opdata1),
    .op2       (opdata2),
    .hit       (fast_hit),
    .result    (fast_result)
  );
`else
  assign fast_hit    = 1'b0;
  assign fast_result = '0;
`endif

  // Next-state and next-register computation for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    // NOTE: every variable gets a hold value first so no path through the case leaves it unassigned (no latches).
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    result_d = result_q;
    valid_d  = valid_q;
    start_d  = start_q;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

    unique case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          req_d.is_signed = req_signed;
          req_d.op1       = opdata1;
          req_d.op2       = opdata2;
          cnt_d           = '0;
          if (fast_hit) begin
            result_d = fast_result;
            cycles_d = '0;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else begin
            start_d = 1'b1;
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_inc;
        // A flush beats a same-cycle div_ready: the result belongs to a killed instruction.
        if (flush) begin
          start_d = 1'b0;
          state_d = IDLE;
        end else if (div_ready) begin
          result_d = div_result;
          cycles_d = cnt_inc;
          valid_d  = 1'b1;
          start_d  = 1'b0;
          state_d  = DONE;
        end
      end

      DONE: begin
        // Stay put while another source freezes the pipe; leave on advance or flush.
        if (flush || !stall_ext) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        start_d = 1'b0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered-output flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: rst is sampled on the clock edge only, so it stays out of the sensitivity list.
    if (!rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
    end
  end

  // Annul the core on flush or reset while it is running; start drops in the same cycle.
  assign div_annul = (state_q == BUSY) && (flush || !rst);
  assign div_start = start_q && !div_annul;

  // Stall the E stage at a core-bound acceptance and while waiting on the core.
  assign stall_req = ((state_q == IDLE) && req_valid && !flush && !fast_hit) ||
                     ((state_q == BUSY) && !div_ready && !flush);

  assign div_signed   = req_q.is_signed;
  assign div_op1      = req_q.op1;
  assign div_op2      = req_q.op2;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign div_cycles   = cycles_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a 32-cycle behavioural divider core.
// The core raises div_ready in the 32nd consecutive cycle of div_start.
module tb_div_seq_ctrl;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int LAT    = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                req_valid, req_signed, flush, stall_ext;
  logic [DATA_W-1:0]   opdata1, opdata2;
  logic                div_start, div_annul, div_signed, div_ready, stall_req, result_valid;
  logic [DATA_W-1:0]   div_op1, div_op2;
  logic [2*DATA_W-1:0] div_result, result;
  logic [CNT_W-1:0]    div_cycles;

  int   checks   = 0;
  int   failures = 0;
  int   core_cnt = 0;
  int   starts   = 0;
  logic start_prev  = 1'b0;
  logic stale_ready = 1'b0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_signed   (req_signed),
    .opdata1      (opdata1),
    .opdata2      (opdata2),
    .flush        (flush),
    .stall_ext    (stall_ext),
    .div_start    (div_start),
    .div_annul    (div_annul),
    .div_signed   (div_signed),
    .div_op1      (div_op1),
    .div_op2      (div_op2),
    .div_result   (div_result),
    .div_ready    (div_ready),
    .stall_req    (stall_req),
    .result       (result),
    .result_valid (result_valid),
    .div_cycles   (div_cycles)
  );

  // Behavioural core: counts start cycles, restarts whenever start drops.
  always @(posedge clk) begin
    core_cnt   <= div_start ? core_cnt + 1 : 0;
    start_prev <= div_start;
    if (div_start && !start_prev) starts <= starts + 1;
  end

  assign div_ready = (div_start && (core_cnt == LAT - 1)) || stale_ready;

  always_comb begin
    if (div_op2 == '0)
      div_result = {div_op1, 32'hFFFF_FFFF};
    else if (div_signed)
      div_result = {$signed(div_op1) % $signed(div_op2), $signed(div_op1) / $signed(div_op2)};
    else
      div_result = {div_op1 % div_op2, div_op1 / div_op2};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a request from IDLE and run until result_valid; operands are scrambled after acceptance.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, output int stalls);
    int n;
    req_valid  = 1'b1;
    req_signed = sgn;
    opdata1    = a;
    opdata2    = b;
    stalls     = 0;
    n          = 0;
    #1;
    while (!result_valid && n < 200) begin
      if (stall_req) stalls++;
      @(posedge clk);
      #1;
      opdata1 = $urandom;
      opdata2 = $urandom;
      #1;
      n++;
    end
    check("div_timeout", 64'(n < 200), 64'd1);
  endtask

  initial begin
    int          stalls;
    int          s0;
    logic [63:0] held;

    req_valid = 1'b0; req_signed = 1'b0; opdata1 = '0; opdata2 = '0;
    flush = 1'b0; stall_ext = 1'b0;

    // Reset
    step(); step();
    rst = 1'b1;
    #1;
    check("rst_result",       result,              64'd0);
    check("rst_result_valid", 64'(result_valid),   64'd0);
    check("rst_div_start",    64'(div_start),      64'd0);
    check("rst_div_cycles",   64'(div_cycles),     64'd0);
    check("rst_stall_req",    64'(stall_req),      64'd0);

    // DIVU 100/7: 1 acceptance + 31 waiting BUSY cycles stalled; ready cycle is not
    run_div(1'b0, 32'd100, 32'd7, stalls);
    check("divu_stall_cycles", 64'(stalls),        64'd32);
    check("divu_result",       result,             {32'd2, 32'd14});
    check("divu_div_cycles",   64'(div_cycles),    64'd32);
    check("divu_valid",        64'(result_valid),  64'd1);
    check("divu_done_stall",   64'(stall_req),     64'd0);
    check("divu_one_start",    64'(starts),        64'd1);
    req_valid = 1'b0;
    step();
    check("divu_valid_1cyc",   64'(result_valid),  64'd0);
    check("divu_no_restart",   64'(div_start),     64'd0);

    // DIV -7/2 -> rem -1, quot -3
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, stalls);
    check("div_signed_result", result,             {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    check("div_signed_flag",   64'(div_signed),    64'd1);
    req_valid = 1'b0;
    step();

    // External hold: DONE held 5 cycles, instruction still presented
    stall_ext = 1'b1;
    s0 = starts;
    run_div(1'b0, 32'd50, 32'd5, stalls);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid",  64'(result_valid), 64'd1);
      check("hold_result", result,            {32'd0, 32'd10});
      check("hold_start",  64'(div_start),    64'd0);
      step();
    end
    stall_ext = 1'b0;
    req_valid = 1'b0;
    #1;
    check("hold_release_valid", 64'(result_valid), 64'd1);
    step();
    check("hold_left_done",     64'(result_valid), 64'd0);
    check("hold_single_start",  64'(starts - s0),  64'd1);
    held = result;

    // Flush at BUSY cycle 10
    req_valid = 1'b1; req_signed = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
    step();
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1;
    req_valid = 1'b0;
    #1;
    check("flush_annul",      64'(div_annul), 64'd1);
    check("flush_stall",      64'(stall_req), 64'd0);
    check("flush_start_low",  64'(div_start), 64'd0);
    step();
    flush = 1'b0;
    #1;
    check("flush_annul_1cyc", 64'(div_annul),    64'd0);
    check("flush_no_valid",   64'(result_valid), 64'd0);
    check("flush_idle_start", 64'(div_start),    64'd0);
    check("flush_discard",    result,            held);
    step(); step();
    check("flush_still_idle", 64'(result_valid), 64'd0);
    run_div(1'b0, 32'd1000, 32'd3, stalls);
    check("post_flush_result", result,          {32'd1, 32'd333});
    check("post_flush_cycles", 64'(div_cycles), 64'd32);
    req_valid = 1'b0;
    step();

    // Reset at BUSY cycle 5, then a stale div_ready in IDLE
    req_valid = 1'b1; req_signed = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    step();
    for (int i = 0; i < 4; i++) step();
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rst_mid_annul", 64'(div_annul), 64'd1);
    step();
    rst = 1'b1;
    #1;
    check("rst_mid_result", result,              64'd0);
    check("rst_mid_valid",  64'(result_valid),   64'd0);
    check("rst_mid_cycles", 64'(div_cycles),     64'd0);
    check("rst_mid_op1",    64'(div_op1),        64'd0);
    check("rst_mid_op2",    64'(div_op2),        64'd0);
    check("rst_mid_start",  64'(div_start),      64'd0);
    check("rst_mid_stall",  64'(stall_req),      64'd0);
    stale_ready = 1'b1;
    step();
    stale_ready = 1'b0;
    #1;
    check("stale_ready_valid",  64'(result_valid), 64'd0);
    check("stale_ready_result", result,            64'd0);
    check("stale_ready_start",  64'(div_start),    64'd0);

    // DIVU 3/9: trivial case
`ifdef DIV_FASTPATH_EN
    s0 = starts;
    req_valid = 1'b1; req_signed = 1'b0; opdata1 = 32'd3; opdata2 = 32'd9;
    #1;
    check("fast_stall",  64'(stall_req), 64'd0);
    check("fast_start",  64'(div_start), 64'd0);
    step();
    check("fast_valid",  64'(result_valid), 64'd1);
    check("fast_result", result,            {32'd3, 32'd0});
    check("fast_cycles", 64'(div_cycles),   64'd0);
    check("fast_no_core", 64'(starts - s0), 64'd0);
`else
    run_div(1'b0, 32'd3, 32'd9, stalls);
    check("slow_3_9_stall",  64'(stalls),      64'd32);
    check("slow_3_9_result", result,           {32'd3, 32'd0});
    check("slow_3_9_cycles", 64'(div_cycles),  64'd32);
`endif
    req_valid = 1'b0;
    step();

    // Flush while DONE is held by stall_ext
    stall_ext = 1'b1;
    run_div(1'b0, 32'd9, 32'd2, stalls);
    check("done_flush_pre", result, {32'd1, 32'd4});
    flush = 1'b1;
    req_valid = 1'b0;
    step();
    flush = 1'b0;
    stall_ext = 1'b0;
    #1;
    check("done_flush_valid", 64'(result_valid), 64'd0);
    check("done_flush_held",  result,            {32'd1, 32'd4});
    check("done_flush_stall", 64'(stall_req),    64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
